// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the single-cycle MIPS core.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(
      input logic [ADDR_W-1:0] a
   );
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with push, pop, flush and an occupancy count.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Issue throttling upstream must make overflow impossible.
   always @(posedge clock) begin
      if (reset && !flush) assert (!(push && count == FULL));
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC, 1-cycle imem interface and prefetch queue toward decode.
// Define FETCH_BYPASS_EN to present a returning word combinationally when empty.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic [ADDR_W-1:0]   instr_pc4,
   input  logic                instr_ready,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic              has_head;
   logic              bypass;
   logic              pop;
   logic              push;
   logic              fifo_pop;
   fetch_entry_t      head;
   fetch_entry_t      entry;

   assign has_head = (count != '0);

`ifdef FETCH_BYPASS_EN
   assign bypass = inflight & ~redirect & ~has_head;
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = has_head | bypass;
   assign pop         = instr_valid & instr_ready & ~redirect;
   assign fifo_pop    = pop & has_head;
   // A bypassed word consumed this cycle never enters storage.
   assign push        = inflight & ~redirect & ~(bypass & instr_ready);

   assign entry = '{pc: inflight_pc, word: imem_rdata};

   assign instr     = bypass ? imem_rdata  : head.word;
   assign instr_pc  = bypass ? inflight_pc : head.pc;
   assign instr_pc4 = instr_pc + 32'd4;

   assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

   assign imem_req  = reset & ~redirect & (occ < DEPTH_W);
   assign imem_addr = fetch_pc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= word_align(redirect_pc);
         inflight <= 1'b0;
      end else if (imem_req) begin
         fetch_pc    <= fetch_pc + 32'd4;
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (fifo_pop),
      .flush (redirect),
      .wdata (entry),
      .rdata (head),
      .count (count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM word at address 4k holds k.
module tb_fetch_queue;
   import mips_pkg::*;

   localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc4;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_pc4   (instr_pc4),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (imem_req) imem_rdata <= imem_addr >> 2;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   // Called in the cycle after a redirect to 0x40 (bits [1:0] masked).
   task automatic follow(input string tg);
      int          first;
      logic [31:0] exp_pc;
      first  = -1;
      exp_pc = 32'h40;
      check({tg, "_valid0"}, 32'(instr_valid), 32'd0);
      check({tg, "_req"}, 32'(imem_req), 32'd1);
      check({tg, "_addr"}, imem_addr, 32'h40);
      for (int d = 1; d <= 8; d++) begin
         if (d > 1) next_cycle();
         if (instr_valid) begin
            if (first < 0) first = d;
            check({tg, "_pc"}, instr_pc, exp_pc);
            check({tg, "_word"}, instr, exp_pc >> 2);
            exp_pc += 32'd4;
         end
      end
      check({tg, "_penalty"}, 32'(first), 32'(LAT + 1));
      check({tg, "_count"}, exp_pc, 32'h40 + 32'(4 * (8 - LAT)));
   endtask

   initial begin
      int exp_k;

      // reset values, observed while reset is held low
      #2;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_pc4", instr_pc4, 32'h4);

      // streaming with decode always ready
      do_reset();
      instr_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) next_cycle();
         check("s_req", 32'(imem_req), 32'd1);
         check("s_addr", imem_addr, 32'(4 * c));
         check("s_valid", 32'(instr_valid), 32'(c >= LAT));
         if (c >= LAT) begin
            check("s_instr", instr, 32'(c - LAT));
            check("s_pc", instr_pc, 32'(4 * (c - LAT)));
            check("s_pc4", instr_pc4, 32'(4 * (c - LAT) + 4));
         end
      end

      // asynchronous reset between clock edges
      #2;
      reset = 1'b0;
      #1;
      check("ar_valid", 32'(instr_valid), 32'd0);
      check("ar_req", 32'(imem_req), 32'd0);
      check("ar_addr", imem_addr, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      for (int c = 0; c <= LAT + 2; c++) begin
         if (c > 0) next_cycle();
         check("ar_raddr", imem_addr, 32'(4 * c));
         check("ar_rvalid", 32'(instr_valid), 32'(c >= LAT));
         if (c >= LAT) check("ar_rpc", instr_pc, 32'(4 * (c - LAT)));
      end

      // decode stalled for 10 cycles: exactly DEPTH words accepted
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         check("st_req", 32'(imem_req), 32'(c < DEPTH));
         if (c >= LAT) begin
            check("st_valid", 32'(instr_valid), 32'd1);
            check("st_instr", instr, 32'h0);
         end
      end
      instr_ready = 1'b1;
      exp_k = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) next_cycle();
         if (instr_valid) begin
            check("st_word", instr, 32'(exp_k));
            check("st_pc", instr_pc, 32'(4 * exp_k));
            exp_k++;
         end
      end
      check("st_delivered", 32'(exp_k), 32'd16);

      // redirect with 3 queued and one in flight; pop in same cycle ignored
      do_reset();
      for (int c = 1; c <= 4; c++) next_cycle();
      check("r1_full_req", 32'(imem_req), 32'd0);
      check("r1_full_valid", 32'(instr_valid), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      instr_ready = 1'b1;
      #1;
      check("r1_req_blk", 32'(imem_req), 32'd0);
      @(negedge clock);
      redirect = 1'b0;
      #1;
      follow("r1");

      // redirect mid-stream with a pop, unaligned target
      redirect    = 1'b1;
      redirect_pc = 32'h43;
      #1;
      check("r2_req_blk", 32'(imem_req), 32'd0);
      @(negedge clock);
      redirect = 1'b0;
      #1;
      follow("r2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
